// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage register with valid/ready handshake, flush, and an
// in-order tracking queue that turns multi-cycle results into write-back slots.
module ex_mem_stage #(
  parameter int XLEN     = 32,
  parameter int CTRL_W   = 8,
  parameter int MC_DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_pc,
  input  logic [4:0]                  in_rd,
  input  logic                        in_int_wr,
  input  logic                        in_fp_wr,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [XLEN-1:0]             in_data,
  input  logic                        in_mc_start,
  input  logic                        mc_done,
  output logic                        mc_ready,
  input  logic [XLEN-1:0]             mc_result,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [4:0]                  out_rd,
  output logic                        out_int_wr,
  output logic                        out_fp_wr,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [XLEN-1:0]             out_data,
  output logic                        out_is_mc,
  output logic [$clog2(MC_DEPTH):0]   mc_count,
  output logic                        mc_full,
  output logic                        mc_err
);

  localparam int PW = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
  localparam int CW = $clog2(MC_DEPTH) + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MC_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  logic              r_out_valid;
  logic              r_out_is_mc;
  logic [31:0]       r_out_pc;
  logic [4:0]        r_out_rd;
  logic              r_out_int_wr;
  logic              r_out_fp_wr;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [XLEN-1:0]   r_out_data;

  logic [31:0]       r_q_pc [MC_DEPTH];
  logic [4:0]        r_q_rd [MC_DEPTH];
  logic              r_q_fp [MC_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              r_rb_valid;
  logic [XLEN-1:0]   r_rb_data;
  logic              r_mc_err;

  logic w_slot_free;
  logic w_q_empty;
  logic w_q_full;
  logic w_in_ready;
  logic w_accept_norm;
  logic w_push;
  logic w_inject;
  logic w_mc_cap;

  assign w_slot_free   = !r_out_valid || out_ready;
  assign w_q_empty     = (r_count == CW'(0));
  assign w_q_full      = (r_count == CW'(MC_DEPTH));
  assign w_in_ready    = w_slot_free && !r_rb_valid && !flush && (!in_mc_start || !w_q_full);
  assign w_accept_norm = in_valid && w_in_ready && !in_mc_start;
  assign w_push        = in_valid && w_in_ready && in_mc_start;
  assign w_inject      = r_rb_valid && w_slot_free && !flush && !w_q_empty;
  assign w_mc_cap      = mc_done && !r_rb_valid;

  // Output slot: flush beats injection, injection beats new input.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_is_mc  <= 1'b0;
      r_out_pc     <= '0;
      r_out_rd     <= '0;
      r_out_int_wr <= 1'b0;
      r_out_fp_wr  <= 1'b0;
      r_out_ctrl   <= '0;
      r_out_data   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_is_mc <= 1'b0;
    end else if (w_inject) begin
      r_out_valid  <= 1'b1;
      r_out_is_mc  <= 1'b1;
      r_out_pc     <= r_q_pc[r_rptr];
      r_out_rd     <= r_q_rd[r_rptr];
      r_out_fp_wr  <= r_q_fp[r_rptr];
      r_out_int_wr <= !r_q_fp[r_rptr];
      r_out_ctrl   <= '0;
      r_out_data   <= r_rb_data;
    end else if (w_accept_norm) begin
      r_out_valid  <= 1'b1;
      r_out_is_mc  <= 1'b0;
      r_out_pc     <= in_pc;
      r_out_rd     <= in_rd;
      r_out_int_wr <= in_int_wr;
      r_out_fp_wr  <= in_fp_wr;
      r_out_ctrl   <= in_ctrl;
      r_out_data   <= in_data;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
      r_out_is_mc <= 1'b0;
    end
  end

  // Pending multi-cycle queue: push on mc issue, pop on injection.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MC_DEPTH; i++) begin
        r_q_pc[i] <= '0;
        r_q_rd[i] <= '0;
        r_q_fp[i] <= 1'b0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wptr] <= in_pc;
        r_q_rd[r_wptr] <= in_rd;
        r_q_fp[r_wptr] <= in_fp_wr;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_inject) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_inject) begin
        r_count <= r_count + CW'(1);
      end else if (w_inject && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Result buffer and sticky error for a completion with nothing pending.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
      r_mc_err   <= 1'b0;
    end else begin
      if (w_inject) begin
        r_rb_valid <= 1'b0;
      end else if (w_mc_cap && !w_q_empty) begin
        r_rb_valid <= 1'b1;
        r_rb_data  <= mc_result;
      end
      if (w_mc_cap && w_q_empty) begin
        r_mc_err <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign mc_ready   = !r_rb_valid;
  assign out_valid  = r_out_valid;
  assign out_is_mc  = r_out_is_mc;
  assign out_pc     = r_out_pc;
  assign out_rd     = r_out_rd;
  assign out_int_wr = r_out_int_wr;
  assign out_fp_wr  = r_out_fp_wr;
  assign out_ctrl   = r_out_ctrl;
  assign out_data   = r_out_data;
  assign mc_count   = r_count;
  assign mc_full    = w_q_full;
  assign mc_err     = r_mc_err;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_ex_mem_stage;
  localparam int XLEN = 32, CTRL_W = 8, MC_DEPTH = 2, CW = $clog2(MC_DEPTH) + 1;

  logic CLK = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_int_wr = 1'b0, in_fp_wr = 1'b0, in_mc_start = 1'b0;
  logic mc_done = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_pc = '0;
  logic [4:0] in_rd = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [XLEN-1:0] in_data = '0, mc_result = '0;
  logic in_ready, mc_ready, out_valid, out_int_wr, out_fp_wr, out_is_mc, mc_full, mc_err;
  logic [31:0] out_pc;
  logic [4:0] out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0] out_data;
  logic [CW-1:0] mc_count;

  ex_mem_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .MC_DEPTH(MC_DEPTH)) dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_int_wr(in_int_wr), .in_fp_wr(in_fp_wr),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_mc_start(in_mc_start),
    .mc_done(mc_done), .mc_ready(mc_ready), .mc_result(mc_result), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_int_wr(out_int_wr), .out_fp_wr(out_fp_wr), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_is_mc(out_is_mc), .mc_count(mc_count),
    .mc_full(mc_full), .mc_err(mc_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct packed {logic [31:0] pc; logic [4:0] rd; logic fp;} mc_ent_t;
  mc_ent_t mq[$];
  logic m_valid, m_is_mc, m_int, m_fp, m_rb, m_err;
  logic [31:0] m_pc;
  logic [4:0] m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  logic [XLEN-1:0] m_data, m_rb_data;

  task automatic model_reset();
    m_valid = 0; m_is_mc = 0; m_int = 0; m_fp = 0; m_rb = 0; m_err = 0;
    m_pc = '0; m_rd = '0; m_ctrl = '0; m_data = '0; m_rb_data = '0;
    mq.delete();
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic cyc(input logic v, ms, d, fl, ordy, input logic [31:0] pc,
                     input logic [4:0] rd, input logic iw, fw,
                     input logic [CTRL_W-1:0] ctl, input logic [XLEN-1:0] dat, res);
    logic e_free, e_full, e_inr, acc, inj, cap;
    mc_ent_t h;
    in_valid = v; in_mc_start = ms; mc_done = d; flush = fl; out_ready = ordy;
    in_pc = pc; in_rd = rd; in_int_wr = iw; in_fp_wr = fw; in_ctrl = ctl;
    in_data = dat; mc_result = res;
    #1;
    e_free = !m_valid || ordy;
    e_full = (mq.size() == MC_DEPTH);
    e_inr  = e_free && !m_rb && !fl && (!ms || !e_full);
    chk("in_ready", in_ready, e_inr);
    chk("mc_ready", mc_ready, !m_rb);
    chk("out_valid", out_valid, m_valid);
    chk("out_is_mc", out_is_mc, m_is_mc);
    chk("mc_count", mc_count, mq.size());
    chk("mc_full", mc_full, e_full);
    chk("mc_err", mc_err, m_err);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rd", out_rd, m_rd);
      chk("out_int_wr", out_int_wr, m_int);
      chk("out_fp_wr", out_fp_wr, m_fp);
      chk("out_ctrl", out_ctrl, m_ctrl);
      chk("out_data", out_data, m_data);
    end
    acc = v && e_inr;
    inj = m_rb && e_free && !fl && (mq.size() != 0);
    cap = d && !m_rb;
    if (cap && mq.size() == 0) m_err = 1;
    if (fl) begin
      m_valid = 0; m_is_mc = 0;
    end else if (inj) begin
      h = mq.pop_front();
      m_valid = 1; m_is_mc = 1; m_pc = h.pc; m_rd = h.rd; m_fp = h.fp; m_int = !h.fp;
      m_ctrl = '0; m_data = m_rb_data;
    end else if (acc && !ms) begin
      m_valid = 1; m_is_mc = 0; m_pc = pc; m_rd = rd; m_int = iw; m_fp = fw;
      m_ctrl = ctl; m_data = dat;
    end else if (e_free) begin
      m_valid = 0; m_is_mc = 0;
    end
    if (acc && ms) mq.push_back('{pc: pc, rd: rd, fp: fw});
    if (inj) m_rb = 0;
    else if (cap && !m_err_discard(cap)) begin
      m_rb = 1; m_rb_data = res;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // A capture counts as a buffered result only if something was pending when it
  // arrived; the pending count seen here is post-update, so use the flag set above.
  logic cap_discard;
  function automatic logic m_err_discard(input logic cap);
    return cap_discard;
  endfunction

  task automatic idle(input logic ordy);
    cyc(0, 0, 0, 0, ordy, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_is_mc", out_is_mc, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_int_wr", out_int_wr, 0);
    chk("rst_out_fp_wr", out_fp_wr, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mc_count", mc_count, 0);
    chk("rst_mc_err", mc_err, 0);
    chk("rst_mc_ready", mc_ready, 1);
    model_reset();
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    logic v, ms, d, fl, ordy;
    model_reset();
    cap_discard = 0;
    @(negedge CLK);
    do_reset();

    // Three back-to-back normal instructions.
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 1, 32'(i * 4), 5'(i + 1), 1, 0, 8'h11, 32'(100 + i), '0);
    chk("stream_pc", out_pc, 32'h8);
    chk("stream_rd", out_rd, 5'd3);

    // Single DIV, result three cycles later.
    cyc(1, 1, 0, 0, 1, 32'h10, 5'd5, 1, 0, 8'h22, 32'h0, '0);
    chk("div_count", mc_count, 1);
    idle(1); idle(1);
    cyc(0, 0, 1, 0, 1, '0, '0, 0, 0, '0, '0, 32'h7);
    chk("div_rb_inrdy", in_ready, 0);
    idle(1);
    chk("div_is_mc", out_is_mc, 1);
    chk("div_rd", out_rd, 5'd5);
    chk("div_data", out_data, 32'h7);
    chk("div_pc", out_pc, 32'h10);
    chk("div_int_wr", out_int_wr, 1);
    chk("div_count0", mc_count, 0);

    // Two DIVs fill the queue; a third is refused; results retire in order.
    cyc(1, 1, 0, 0, 1, 32'h20, 5'd6, 1, 0, '0, '0, '0);
    cyc(1, 1, 0, 0, 1, 32'h24, 5'd7, 0, 1, '0, '0, '0);
    chk("full_flag", mc_full, 1);
    cyc(1, 1, 0, 0, 1, 32'h28, 5'd8, 1, 0, '0, '0, '0);
    cyc(0, 0, 1, 0, 1, '0, '0, 0, 0, '0, '0, 32'h66);
    idle(1);
    chk("order_rd6", out_rd, 5'd6);
    cyc(0, 0, 1, 0, 1, '0, '0, 0, 0, '0, '0, 32'h77);
    idle(1);
    chk("order_rd7", out_rd, 5'd7);
    chk("order_fp7", out_fp_wr, 1);

    // Stall with a buffered result, then release.
    cyc(1, 1, 0, 0, 1, 32'h30, 5'd9, 1, 0, '0, '0, '0);
    cyc(1, 0, 0, 0, 1, 32'h40, 5'd12, 1, 0, 8'h5a, 32'h1234, '0);
    cyc(0, 0, 1, 0, 0, '0, '0, 0, 0, '0, '0, 32'h99);
    cyc(0, 0, 1, 0, 0, '0, '0, 0, 0, '0, '0, 32'hAA);
    chk("stall_mc_ready", mc_ready, 0);
    chk("stall_pc", out_pc, 32'h40);
    idle(1);
    chk("stall_inj", out_is_mc, 1);
    chk("stall_data", out_data, 32'h99);

    // Flush with one DIV pending.
    cyc(1, 1, 0, 0, 1, 32'h50, 5'd10, 1, 0, '0, '0, '0);
    cyc(1, 0, 0, 0, 1, 32'h54, 5'd11, 1, 0, '0, 32'h5, '0);
    cyc(0, 0, 0, 1, 0, '0, '0, 0, 0, '0, '0, '0);
    chk("flush_valid", out_valid, 0);
    chk("flush_count", mc_count, 1);
    cyc(0, 0, 1, 0, 1, '0, '0, 0, 0, '0, '0, 32'hBB);
    idle(1);
    chk("flush_inj_rd", out_rd, 5'd10);
    chk("flush_inj_data", out_data, 32'hBB);

    // Spurious completion with nothing pending.
    idle(1);
    cap_discard = 1;
    cyc(0, 0, 1, 0, 1, '0, '0, 0, 0, '0, '0, 32'h55);
    cap_discard = 0;
    chk("err_set", mc_err, 1);
    chk("err_no_valid", out_valid, 0);
    idle(1); idle(1);
    chk("err_sticky", mc_err, 1);
    do_reset();

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      v  = ($urandom_range(0, 9) < 7);
      ms = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 99) < 8);
      ordy = ($urandom_range(0, 9) < 7);
      if (mq.size() != 0) d = ($urandom_range(0, 9) < 3);
      else d = ($urandom_range(0, 99) < 3);
      cap_discard = d && !m_rb && (mq.size() == 0);
      cyc(v, ms, d, fl, ordy, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
          8'($urandom), $urandom, $urandom);
      cap_discard = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
